// File: rtl/avm_pkg.sv
// Shared definitions for the UART Avalon-MM access path: register map,
// status bit positions and the arbiter FSM state type.
package avm_pkg;

  // UART register offsets as seen on the Avalon address bus.
  typedef enum logic [4:0] {
    RX_BASE     = 5'd0,
    TX_BASE     = 5'd4,
    STATUS_BASE = 5'd8
  } uart_reg_e;

  // Bit positions inside the STATUS register.
  typedef enum int {
    TX_OK_BIT = 6,
    RX_OK_BIT = 7
  } uart_status_bit_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/avm_uart_arbiter_if.sv
// Requester-side request/response signals plus the Avalon-MM master bus.
// The master modport is the arbiter's view; slave is the environment's.
interface avm_uart_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_write;
  logic [N_REQ*ADDR_W-1:0] req_address;
  logic [N_REQ*DATA_W-1:0] req_writedata;
  logic [N_REQ-1:0]        req_done;
  logic [DATA_W-1:0]       rsp_readdata;
  logic                    rsp_error;

  logic [ADDR_W-1:0]       avm_address;
  logic                    avm_read;
  logic                    avm_write;
  logic [DATA_W-1:0]       avm_writedata;
  logic [DATA_W-1:0]       avm_readdata;
  logic                    avm_waitrequest;

  modport master (
    input  req_valid, req_write, req_address, req_writedata,
    input  avm_readdata, avm_waitrequest,
    output req_done, rsp_readdata, rsp_error,
    output avm_address, avm_read, avm_write, avm_writedata
  );

  modport slave (
    output req_valid, req_write, req_address, req_writedata,
    output avm_readdata, avm_waitrequest,
    input  req_done, rsp_readdata, rsp_error,
    input  avm_address, avm_read, avm_write, avm_writedata
  );

endinterface

// File: rtl/avm_uart_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward from last_grant_i+1, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic             any_o,
  output logic [IDX_W-1:0] grant_o
);

  always_comb begin
    int idx;
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    // Offset N_REQ lands back on last_grant_i, so it is checked last.
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_grant_i) + off) % N_REQ;
      if (!any_o && req_i[IDX_W'(idx)]) begin
        any_o   = 1'b1;
        grant_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/avm_uart_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between N_REQ requesters;
// one access in flight, strobe 1 cycle after request, done 1 cycle after waitrequest drops.
module avm_uart_arbiter
  import avm_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic                avm_clk,
  input logic                avm_rst,
  avm_uart_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  req_eff;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;

  // The requester just completed may still hold req_valid this cycle;
  // masking it keeps the finished access from being issued twice.
  assign req_eff = bus.req_valid & ~done_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i        (req_eff),
    .last_grant_i (last_q),
    .any_o        (pick_any),
    .grant_o      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (pick_any) begin
          grant_d = pick_idx;
          addr_d  = bus.req_address[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d = bus.req_writedata[int'(pick_idx)*DATA_W +: DATA_W];
          wr_d    = bus.req_write[pick_idx];
          rd_d    = ~bus.req_write[pick_idx];
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        if (!bus.avm_waitrequest) begin
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d           = 1'b0;
          if (rd_q) begin
            rdata_d = bus.avm_readdata;
          end
          last_d  = grant_q;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This stalled cycle is the TIMEOUT-th one: give up on the slave.
          rd_d            = 1'b0;
          wr_d            = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = '0;
          last_d          = grant_q;
          state_d         = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = wdata_q;
  assign bus.avm_read      = rd_q;
  assign bus.avm_write     = wr_q;
  assign bus.req_done      = done_q;
  assign bus.rsp_readdata  = rdata_q;
  assign bus.rsp_error     = err_q;

  strobe_exclusive_a : assert property (
    @(posedge avm_clk) disable iff (avm_rst) !(rd_q && wr_q)
  );

endmodule

// File: tb/tb_avm_uart_arbiter.sv
// Directed bench for avm_uart_arbiter with N_REQ=2, TIMEOUT=5.
module tb_avm_uart_arbiter;
  import avm_pkg::*;

  typedef struct {
    string       nm;
    logic [1:0]  vld;
    logic [1:0]  wr;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] rdd;
    logic        wreq;
    logic        e_rd;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic [1:0]  e_done;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  avm_uart_arbiter_if #(.N_REQ(2), .ADDR_W(5), .DATA_W(32)) bus_if ();

  avm_uart_arbiter #(
    .N_REQ   (2),
    .ADDR_W  (5),
    .DATA_W  (32),
    .TIMEOUT (5)
  ) dut (
    .avm_clk (clk),
    .avm_rst (rst),
    .bus     (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string nm, input logic [1:0] vld, input logic [1:0] wr,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [31:0] rdd, input logic wreq,
                     input logic e_rd, input logic e_wr, input logic [4:0] e_addr,
                     input logic [31:0] e_wd, input logic [1:0] e_done,
                     input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.nm = nm; v.vld = vld; v.wr = wr; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.rdd = rdd; v.wreq = wreq;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_done = e_done; v.e_rdata = e_rdata; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] vld, input logic [1:0] wr,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [31:0] rdd, input logic wreq);
    bus_if.req_valid       = vld;
    bus_if.req_write       = wr;
    bus_if.req_address     = {a1, a0};
    bus_if.req_writedata   = {wd1, wd0};
    bus_if.avm_readdata    = rdd;
    bus_if.avm_waitrequest = wreq;
  endtask

  // Strobe exclusivity is checked on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if (!(bus_if.avm_read && bus_if.avm_write)) n_pass++;
      else $display("FAIL excl_strobe: read=1 write=1, required at most one");
    end
  end

  initial begin
    logic [73:0] act;
    logic [73:0] exp;
    logic [4:0]  st;
    logic [31:0] rx_ok;
    n_chk  = 0;
    n_pass = 0;
    st     = STATUS_BASE;
    rx_ok  = 32'd1 << RX_OK_BIT;

    // Single read, zero wait states.
    add("rd_idle",   2'b01, 2'b00, st, 5'd0, 0, 0, rx_ok, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    add("rd_strobe", 2'b01, 2'b00, st, 5'd0, 0, 0, rx_ok, 0, 1, 0, st, 0, 2'b00, 0, 0);
    add("rd_done",   2'b00, 2'b00, st, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, rx_ok, 0);
    add("rd_after",  2'b00, 2'b00, st, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // Write from requester 1 with three wait states; rsp_readdata must be untouched.
    add("wr_req",    2'b10, 2'b10, 5'd0, TX_BASE, 0, 32'h41, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    add("wr_ws1",    2'b10, 2'b10, 5'd0, TX_BASE, 0, 32'h41, 0, 1, 0, 1, TX_BASE, 32'h41, 2'b00, 0, 0);
    add("wr_ws2",    2'b10, 2'b10, 5'd0, TX_BASE, 0, 32'h41, 0, 1, 0, 1, TX_BASE, 32'h41, 2'b00, 0, 0);
    add("wr_ws3",    2'b10, 2'b10, 5'd0, TX_BASE, 0, 32'h41, 0, 1, 0, 1, TX_BASE, 32'h41, 2'b00, 0, 0);
    add("wr_last",   2'b10, 2'b10, 5'd0, TX_BASE, 0, 32'h41, 0, 0, 0, 1, TX_BASE, 32'h41, 2'b00, 0, 0);
    add("wr_done",   2'b00, 2'b00, 5'd0, TX_BASE, 0, 32'h41, 0, 0, 0, 0, 0, 0, 2'b10, rx_ok, 0);
    // Contention: both reading continuously, grants must alternate 0,1,0,1...
    add("cn_start",  2'b11, 2'b00, st, RX_BASE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) begin
      add($sformatf("cn_strobe%0d", k), 2'b11, 2'b00, st, RX_BASE, 0, 0, 32'h100 + k, 0,
          1, 0, (k % 2 == 1) ? RX_BASE : st, 0, 2'b00, 0, 0);
      add($sformatf("cn_done%0d", k), (k == 7) ? 2'b00 : 2'b11, 2'b00, st, RX_BASE, 0, 0, 0, 0,
          0, 0, 0, 0, (k % 2 == 1) ? 2'b10 : 2'b01, 32'h100 + k, 0);
    end
    add("cn_idle",   2'b00, 2'b00, st, RX_BASE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // Requester 1 drops req_valid right after grant; access still completes once.
    add("dp_req",    2'b10, 2'b10, 5'd0, TX_BASE, 0, 32'h55, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    add("dp_strobe", 2'b00, 2'b00, 5'd0, TX_BASE, 0, 32'h55, 0, 0, 0, 1, TX_BASE, 32'h55, 2'b00, 0, 0);
    add("dp_done",   2'b00, 2'b00, 5'd0, TX_BASE, 0, 32'h55, 0, 0, 0, 0, 0, 0, 2'b10, 32'h107, 0);
    add("dp_after1", 2'b00, 2'b00, 5'd0, TX_BASE, 0, 32'h55, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    add("dp_after2", 2'b00, 2'b00, 5'd0, TX_BASE, 0, 32'h55, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // Timeout: slave never responds, strobe held 5 cycles then aborted.
    add("to_req",    2'b01, 2'b00, RX_BASE, 5'd0, 0, 0, 32'hdead, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      add($sformatf("to_wait%0d", k), 2'b01, 2'b00, RX_BASE, 5'd0, 0, 0, 32'hdead, 1,
          1, 0, RX_BASE, 0, 2'b00, 0, 0);
    end
    add("to_abort",  2'b00, 2'b00, RX_BASE, 5'd0, 0, 0, 32'hdead, 1, 0, 0, 0, 0, 2'b01, 32'h0, 1);
    add("to_after",  2'b00, 2'b00, RX_BASE, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    drive(2'b00, 2'b00, 5'd0, 5'd0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_state",
        128'({bus_if.avm_read, bus_if.avm_write, bus_if.req_done, bus_if.avm_address,
              bus_if.avm_writedata, bus_if.rsp_readdata, bus_if.rsp_error}), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].wr, vecs[i].a0, vecs[i].a1,
            vecs[i].wd0, vecs[i].wd1, vecs[i].rdd, vecs[i].wreq);
      @(negedge clk);
      act = {bus_if.avm_read, bus_if.avm_write, bus_if.req_done,
             (vecs[i].e_rd || vecs[i].e_wr) ? bus_if.avm_address : 5'd0,
             vecs[i].e_wr ? bus_if.avm_writedata : 32'd0,
             (vecs[i].e_done != 2'b00) ? bus_if.rsp_readdata : 32'd0,
             (vecs[i].e_done != 2'b00) ? bus_if.rsp_error : 1'b0};
      exp = {vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_done,
             (vecs[i].e_rd || vecs[i].e_wr) ? vecs[i].e_addr : 5'd0,
             vecs[i].e_wr ? vecs[i].e_wd : 32'd0,
             (vecs[i].e_done != 2'b00) ? vecs[i].e_rdata : 32'd0,
             (vecs[i].e_done != 2'b00) ? vecs[i].e_err : 1'b0};
      chk(vecs[i].nm, 128'(act), 128'(exp));
      @(posedge clk);
      #1;
    end

    // Async reset while requester 0's read is stalled on the bus.
    drive(2'b01, 2'b00, st, TX_BASE, 0, 0, 32'hbeef, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pre_read", 128'({bus_if.avm_read, bus_if.avm_address}), 128'({1'b1, st}));
    #2 rst = 1'b1;
    #1;
    chk("rst_async_drop", 128'({bus_if.avm_read, bus_if.avm_write, bus_if.req_done}), 128'd0);
    drive(2'b11, 2'b00, st, TX_BASE, 0, 0, 32'h77, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_nodone", 128'({bus_if.avm_read, bus_if.req_done}), 128'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_idle", 128'({bus_if.avm_read, bus_if.avm_write, bus_if.req_done}), 128'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_first_grant", 128'({bus_if.avm_read, bus_if.avm_address}), 128'({1'b1, st}));
    @(posedge clk);
    #1 drive(2'b10, 2'b00, st, TX_BASE, 0, 0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_first_done", 128'({bus_if.req_done, bus_if.rsp_readdata, bus_if.rsp_error}),
        128'({2'b01, 32'h77, 1'b0}));
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/avm_uart_arbiter.md
Name: avm_uart_arbiter

Overview:
Shares the single Avalon-MM master port to the RS232 UART between N_REQ requesters, e.g. the RX-poll engine and the TX-send engine of the RSA wrapper.
- Accepts one register access per requester at a time.
- Grants round-robin and drives exactly one Avalon read or write, holding it through avm_waitrequest.
- Returns a done pulse, the read data and an error flag to the granted requester.
- Sits between the requester FSMs and the UART slave.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 5, Avalon address width
DATA_W, 32, Avalon data width
TIMEOUT, 255, max cycles avm_waitrequest may stay high before abort

Ports:
avm_clk  in  1  clock
avm_rst  in  1  reset, asynchronous, active-high
req_valid  in  N_REQ  per-requester access request; held until its req_done
req_write  in  N_REQ  1 = write, 0 = read
req_address  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_writedata  in  N_REQ*DATA_W  packed write data
req_done  out  N_REQ  one-cycle completion pulse to the granted requester
rsp_readdata  out  DATA_W  captured read data; valid when req_done is high
rsp_error  out  1  high with req_done when the access timed out
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read strobe
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  Avalon write data
avm_readdata  in  DATA_W  Avalon read data
avm_waitrequest  in  1  Avalon stall

Behaviour:
- Reset values:
  - avm_read, avm_write, avm_address, avm_writedata, req_done, rsp_readdata, rsp_error all 0.
  - state = S_IDLE, grant = 0, last_grant = N_REQ-1, so requester 0 wins first, timeout counter = 0.
- All outputs are registered.
- S_IDLE:
  - If any req_valid is high, pick the first set bit searching from last_grant+1 with wrap modulo N_REQ.
  - Latch grant, address, writedata and write.
  - Next cycle: avm_read or avm_write = 1 and state = S_BUS.
  - If no request, stay in S_IDLE with strobes 0.
- S_BUS:
  - Address, data and strobe are held constant while avm_waitrequest = 1; the counter increments each such cycle.
  - On the first cycle with avm_waitrequest = 0, the transfer completes:
    - Next cycle: strobes = 0, req_done[grant] = 1, rsp_readdata = avm_readdata for reads (unchanged for writes), rsp_error = 0, last_grant = grant, state = S_IDLE.
  - If the counter reaches TIMEOUT with waitrequest still 1, abort:
    - Next cycle: strobes = 0, req_done[grant] = 1, rsp_error = 1, rsp_readdata = 0, last_grant = grant, state = S_IDLE.
- Latency, zero wait states:
  - req_valid sampled at cycle 0, strobe high in cycle 1, req_done in cycle 2.
  - S_IDLE re-arbitrates in cycle 2, so back-to-back accesses issue at most one strobe every 2 cycles.
- Requester contract:
  - A requester keeps req_valid high until it sees req_done.
  - In the req_done cycle it may drop req_valid or present a new request; the arbiter ignores req_valid[grant] in that cycle so the completed request is never re-issued.
  - Dropping req_valid after grant does not cancel the access; it completes normally.
- Simultaneous requests: strict round-robin. With N_REQ = 2 and both requesters continuously requesting, grants alternate 0,1,0,1…
- avm_read and avm_write are never high together; at most one outstanding access.
- Reset mid-access: strobes drop asynchronously, no req_done is issued, and arbitration restarts with requester 0 priority.
- Counter width is clog2(TIMEOUT+1); it is cleared on each new grant.

Decomposition:
- Shared package avm_pkg:
  - UART register offsets RX_BASE = 0, TX_BASE = 4, STATUS_BASE = 8.
  - Status bits TX_OK_BIT = 6, RX_OK_BIT = 7.
  - State enum {S_IDLE, S_BUS}.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: req vector and last_grant. Outputs: any flag and grant index.

Test Plan:
- Single read, waitrequest = 0: req0 read addr 8, readdata 0x80 → avm_read high for 1 cycle at addr 8; req_done = 01 two cycles after request; rsp_readdata = 0x80; rsp_error = 0.
- Write with 3 wait cycles: req1 write addr 4, data 0x41 → avm_write, address 4 and writedata 0x41 stable for 4 cycles; req_done = 10 one cycle after waitrequest falls.
- Contention: req0 and req1 both asserted continuously for 4 accesses each → grant order 0,1,0,1,0,1,0,1; never both strobes high.
- Timeout: TIMEOUT = 5, waitrequest held 1 → strobe high for 5 cycles then drops; req_done pulses with rsp_error = 1 and rsp_readdata = 0.
- Async reset asserted while avm_read is high and stalled → avm_read = 0 immediately, no req_done; after release with both requesting, requester 0 is granted first.
- Requester drops req_valid in the cycle after grant → access still completes and req_done still pulses; no second strobe for that requester.
